irq_request_latch: RTL

IRQ_REQUEST_LATCH -- requirements
Module: irq_request_latch

---
 rtl/irq_request_latch.sv | 87 ++++++++
 1 files changed

// File: rtl/irq_request_latch.sv
// Latches falling edges on eight active-low interrupt requests and presents a frozen snapshot to an 8-to-3 priority encoder until the consumer acknowledges it.
// Define IRQ_LEVEL_MODE_EN to make pending follow the synchronized request level instead of latching edges.
module irq_request_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] REQ_N,
    input  logic       MASK_WE,
    input  logic [7:0] MASK_D,
    input  logic       ACK,
    input  logic [2:0] ACK_ID,
    output logic [7:0] I,
    output logic       EI,
    output logic       BUSY
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] prev;
    logic [7:0] pending;
    logic [7:0] snap;
    logic [7:0] mask;
    logic [7:0] clr;
    logic [7:0] unmasked;
    logic [2:0] ackbit;

    // ACK_ID is the encoder's complemented code; only an ACK seen in HOLD may clear a pending bit
    always_comb begin
        ackbit   = ~ACK_ID;
        clr      = 8'h00;
        if (state == HOLD && ACK)
            clr[ackbit] = 1'b1;
        unmasked = pending & ~mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sync1   <= 8'hFF;
            sync2   <= 8'hFF;
            prev    <= 8'hFF;
            pending <= 8'h00;
            snap    <= 8'h00;
            mask    <= 8'h00;
            BUSY    <= 1'b0;
        end else begin
            sync1 <= REQ_N;
            sync2 <= sync1;
            prev  <= sync2;

            if (MASK_WE)
                mask <= MASK_D;

`ifdef IRQ_LEVEL_MODE_EN
            pending <= ~sync2 & ~clr;
`else
            // A new edge wins over a same-cycle clear of the same bit
            pending <= (pending & ~clr) | (prev & ~sync2);
`endif

            case (state)
                IDLE: begin
                    if (unmasked != 8'h00) begin
                        snap  <= unmasked;
                        BUSY  <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ACK) begin
                        snap  <= 8'h00;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // snap is non-zero exactly while held, so the encoder view derives straight from flops
    assign I  = ~snap;
    assign EI = ~BUSY;

endmodule
